sram_burst_ctrl: RTL and testbench

//  Parametrised SRAM access controller: runs single or burst reads/writes with programmable wait states
//  and per-word data handshakes. Sits between the datapath (address, burst length, data) and the

---
 rtl/sram_burst_ctrl_if.sv | 35 +++
 rtl/sram_burst_ctrl.sv | 112 +++++++++++
 tb/tb_sram_burst_ctrl.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_burst_ctrl_if.sv
// Bundles the datapath-side request/response signals and the external SRAM pins of
// sram_burst_ctrl. slave = the controller, master = datapath plus SRAM.
interface sram_burst_ctrl_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned LEN_W  = 4
);
    logic              start;
    logic              writemode;
    logic [ADDR_W-1:0] i_address;
    logic [LEN_W-1:0]  i_burst_len;
    logic [DATA_W-1:0] i_w_data;
    logic              o_w_req;
    logic [DATA_W-1:0] o_r_data;
    logic              o_r_valid;
    logic              io_done;
    logic              busy;
    logic              read_enable;
    logic              write_enable;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] w_data;
    logic [DATA_W-1:0] r_data;

    modport slave (
        input  start, writemode, i_address, i_burst_len, i_w_data, r_data,
        output o_w_req, o_r_data, o_r_valid, io_done, busy,
        output read_enable, write_enable, address, w_data
    );

    modport master (
        output start, writemode, i_address, i_burst_len, i_w_data, r_data,
        input  o_w_req, o_r_data, o_r_valid, io_done, busy,
        input  read_enable, write_enable, address, w_data
    );
endinterface

// File: rtl/sram_burst_ctrl.sv
// SRAM access controller: single or burst reads/writes, each word holding its strobe for
// WAIT_CYCLES cycles followed by a one-cycle turnaround. All SRAM-facing outputs are registered.
module sram_burst_ctrl #(
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned WAIT_CYCLES = 3,
    parameter int unsigned LEN_W       = 4
) (
    input logic                clk,
    input logic                n_rst,
    sram_burst_ctrl_if.slave   bus
);
    localparam int unsigned WAIT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StAccess, StRecover} state_e;

    state_e            r_state,    w_state_d;
    logic              r_write,    w_write_d;
    logic [WAIT_W-1:0] r_wait_cnt, w_wait_cnt_d;
    logic [LEN_W-1:0]  r_word_cnt, w_word_cnt_d;
    logic              r_re,       w_re_d;
    logic              r_we,       w_we_d;
    logic [ADDR_W-1:0] r_addr,     w_addr_d;
    logic [DATA_W-1:0] r_wdata,    w_wdata_d;
    logic [DATA_W-1:0] r_rdata,    w_rdata_d;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state    <= StIdle;
            r_write    <= 1'b0;
            r_wait_cnt <= '0;
            r_word_cnt <= '0;
            r_re       <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
        end else begin
            r_state    <= w_state_d;
            r_write    <= w_write_d;
            r_wait_cnt <= w_wait_cnt_d;
            r_word_cnt <= w_word_cnt_d;
            r_re       <= w_re_d;
            r_we       <= w_we_d;
            r_addr     <= w_addr_d;
            r_wdata    <= w_wdata_d;
            r_rdata    <= w_rdata_d;
        end
    end

    always_comb begin
        w_state_d    = r_state;
        w_write_d    = r_write;
        w_wait_cnt_d = r_wait_cnt;
        w_word_cnt_d = r_word_cnt;
        w_re_d       = 1'b0;
        w_we_d       = 1'b0;
        w_addr_d     = r_addr;
        w_wdata_d    = r_wdata;
        w_rdata_d    = r_rdata;
        unique case (r_state)
            StIdle: begin
                if (bus.start) begin
                    w_state_d    = StAccess;
                    w_write_d    = bus.writemode;
                    w_wait_cnt_d = '0;
                    w_word_cnt_d = bus.i_burst_len;
                    w_addr_d     = bus.i_address;
                    w_re_d       = !bus.writemode;
                    w_we_d       = bus.writemode;
                    if (bus.writemode) w_wdata_d = bus.i_w_data;
                end
            end
            StAccess: begin
                if (r_wait_cnt == WAIT_LAST) begin
                    w_state_d    = StRecover;
                    w_wait_cnt_d = '0;
                    if (!r_write) w_rdata_d = bus.r_data;
                end else begin
                    w_wait_cnt_d = r_wait_cnt + WAIT_W'(1);
                    w_re_d       = r_re;
                    w_we_d       = r_we;
                end
            end
            StRecover: begin
                if (r_word_cnt == '0) begin
                    w_state_d = StIdle;
                end else begin
                    // Next word of the burst: address wraps naturally at 2^ADDR_W.
                    w_state_d    = StAccess;
                    w_word_cnt_d = r_word_cnt - LEN_W'(1);
                    w_addr_d     = r_addr + ADDR_W'(1);
                    w_re_d       = !r_write;
                    w_we_d       = r_write;
                    if (r_write) w_wdata_d = bus.i_w_data;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    assign bus.busy         = (r_state != StIdle);
    assign bus.read_enable  = r_re;
    assign bus.write_enable = r_we;
    assign bus.address      = r_addr;
    assign bus.w_data       = r_wdata;
    assign bus.o_r_data     = r_rdata;
    assign bus.o_r_valid    = (r_state == StRecover) && !r_write;
    assign bus.io_done      = (r_state == StRecover) && (r_word_cnt == '0);
    assign bus.o_w_req      = (r_state == StRecover) && r_write && (r_word_cnt != '0);
endmodule

// File: tb/tb_sram_burst_ctrl.sv
// Bench for sram_burst_ctrl: two instances (WAIT=3/DATA=8 and WAIT=1/DATA=16) share stimulus
// and are each compared every cycle against a transaction-level model.
module tb_sram_burst_ctrl;
    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic        start = 1'b0;
    logic        wmode = 1'b0;
    logic [15:0] addr_in = '0;
    logic [3:0]  len_in = '0;
    logic [15:0] wd_a = '0;
    logic [15:0] wd_b = '0;
    logic [15:0] mem [0:65535];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sram_burst_ctrl_if #(.ADDR_W(16), .DATA_W(8),  .LEN_W(4)) bus_a ();
    sram_burst_ctrl_if #(.ADDR_W(16), .DATA_W(16), .LEN_W(4)) bus_b ();

    sram_burst_ctrl #(.ADDR_W(16), .DATA_W(8), .WAIT_CYCLES(3), .LEN_W(4)) dut_a (
        .clk(clk), .n_rst(n_rst), .bus(bus_a)
    );
    sram_burst_ctrl #(.ADDR_W(16), .DATA_W(16), .WAIT_CYCLES(1), .LEN_W(4)) dut_b (
        .clk(clk), .n_rst(n_rst), .bus(bus_b)
    );

    assign bus_a.start = start;
    assign bus_a.writemode = wmode;
    assign bus_a.i_address = addr_in;
    assign bus_a.i_burst_len = len_in;
    assign bus_a.i_w_data = wd_a[7:0];
    assign bus_a.r_data = mem[bus_a.address][7:0];
    assign bus_b.start = start;
    assign bus_b.writemode = wmode;
    assign bus_b.i_address = addr_in;
    assign bus_b.i_burst_len = len_in;
    assign bus_b.i_w_data = wd_b;
    assign bus_b.r_data = mem[bus_b.address];

    // {busy, re, we, w_req, r_valid, done, address, w_data, r_data}
    logic [53:0] obs_a, obs_b;
    assign obs_a = {bus_a.busy, bus_a.read_enable, bus_a.write_enable, bus_a.o_w_req,
                    bus_a.o_r_valid, bus_a.io_done, bus_a.address, 8'h00, bus_a.w_data,
                    8'h00, bus_a.o_r_data};
    assign obs_b = {bus_b.busy, bus_b.read_enable, bus_b.write_enable, bus_b.o_w_req,
                    bus_b.o_r_valid, bus_b.io_done, bus_b.address, bus_b.w_data, bus_b.o_r_data};

    // k = cycle number since the accepting edge; word = (k-1)/(W+1), phase = (k-1)%(W+1).
    typedef struct {
        bit          busy;
        int          k;
        bit          wr;
        logic [15:0] addr;
        int          len;
        logic [15:0] wd;
        logic [15:0] rd;
    } model_t;

    model_t ma, mb;

    function automatic model_t model_reset();
        model_t m;
        m.busy = 1'b0; m.k = 0; m.wr = 1'b0; m.addr = '0; m.len = 0; m.wd = '0; m.rd = '0;
        return m;
    endfunction

    function automatic model_t step(model_t m, int w, logic [15:0] mask, logic st, logic wm,
                                    logic [15:0] ai, logic [3:0] li, logic [15:0] wdi);
        model_t n = m;
        int idx, ph;
        if (!m.busy) begin
            if (st) begin
                n.busy = 1'b1; n.k = 1; n.wr = wm; n.addr = ai; n.len = int'(li);
                if (wm) n.wd = wdi & mask;
            end
        end else begin
            idx = (m.k - 1) / (w + 1);
            ph  = (m.k - 1) % (w + 1);
            if (!m.wr && ph == w - 1) n.rd = mem[m.addr] & mask;
            if (ph == w) begin
                if (idx == m.len) n.busy = 1'b0;
                else begin
                    n.addr = m.addr + 16'd1;
                    if (m.wr) n.wd = wdi & mask;
                end
            end
            n.k = m.k + 1;
        end
        return n;
    endfunction

    function automatic logic [53:0] exp_obs(model_t m, int w);
        int idx = 0, ph = 0;
        bit en, rec, last;
        if (m.busy) begin
            idx = (m.k - 1) / (w + 1);
            ph  = (m.k - 1) % (w + 1);
        end
        en   = m.busy && ph < w;
        rec  = m.busy && ph == w;
        last = idx == m.len;
        return {m.busy, en && !m.wr, en && m.wr, rec && m.wr && !last, rec && !m.wr,
                rec && last, m.addr, m.wd, m.rd};
    endfunction

    // Index of the write word the DUT will sample at the next edge, or -1.
    function automatic int next_word(model_t m, int w);
        if (m.busy && m.wr && ((m.k - 1) % (w + 1)) == w) return (m.k - 1) / (w + 1) + 1;
        return -1;
    endfunction

    task automatic check(string name, logic [53:0] act, logic [53:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_int(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Called at a negedge with inputs set; returns at the following negedge after checking.
    task automatic cycle();
        model_t na, nb;
        na = step(ma, 3, 16'h00FF, start, wmode, addr_in, len_in, wd_a);
        nb = step(mb, 1, 16'hFFFF, start, wmode, addr_in, len_in, wd_b);
        @(posedge clk);
        ma = na;
        mb = nb;
        @(negedge clk);
        check("cycle dut_a", obs_a, exp_obs(ma, 3));
        check("cycle dut_b", obs_b, exp_obs(mb, 1));
    endtask

    typedef struct {
        bit          wr;
        logic [15:0] addr;
        logic [3:0]  len;
        logic [15:0] d0, d1, d2;
        logic [15:0] exp_data;
        int          done_a, done_b, wreq;
    } vec_t;

    function automatic logic [15:0] word_of(vec_t v, int n);
        if (n == 0) return v.d0;
        if (n == 1) return v.d1;
        return v.d2;
    endfunction

    task automatic apply_vec(vec_t v, int id);
        int da = -1, db = -1, qa = 0, qb = 0, na, nb;
        start = 1'b1; wmode = v.wr; addr_in = v.addr; len_in = v.len;
        wd_a = v.d0; wd_b = v.d0;
        for (int t = 1; t <= 100; t++) begin
            cycle();
            if (bus_a.io_done && da < 0) da = t;
            if (bus_b.io_done && db < 0) db = t;
            if (bus_a.o_w_req) qa++;
            if (bus_b.o_w_req) qb++;
            // Noise on start and request fields while both are busy must be ignored.
            if (ma.busy && mb.busy) begin
                start = 1'($urandom); wmode = 1'($urandom);
                addr_in = 16'($urandom); len_in = 4'($urandom);
            end else begin
                start = 1'b0;
            end
            na = next_word(ma, 3);
            nb = next_word(mb, 1);
            wd_a = (na >= 0) ? word_of(v, na) : 16'hDEAD;
            wd_b = (nb >= 0) ? word_of(v, nb) : 16'hBEEF;
            if (!ma.busy && !mb.busy) break;
        end
        start = 1'b0;
        check_int($sformatf("vec%0d idle_a", id), int'(bus_a.busy), 0);
        check_int($sformatf("vec%0d idle_b", id), int'(bus_b.busy), 0);
        check_int($sformatf("vec%0d done_cycle_a", id), da, v.done_a);
        check_int($sformatf("vec%0d done_cycle_b", id), db, v.done_b);
        check_int($sformatf("vec%0d w_req_a", id), qa, v.wreq);
        check_int($sformatf("vec%0d w_req_b", id), qb, v.wreq);
        check_int($sformatf("vec%0d data_a", id),
                  int'(v.wr ? bus_a.w_data : bus_a.o_r_data), int'(v.exp_data[7:0]));
        check_int($sformatf("vec%0d data_b", id),
                  int'(v.wr ? bus_b.w_data : bus_b.o_r_data), int'(v.exp_data));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[5];
        vecs[0] = '{1'b1, 16'h1234, 4'd0,  16'h00A5, 16'h0,    16'h0,    16'h00A5, 4,  2,  0};
        vecs[1] = '{1'b0, 16'h0010, 4'd0,  16'h0,    16'h0,    16'h0,    16'h003C, 4,  2,  0};
        vecs[2] = '{1'b0, 16'hFFFE, 4'd3,  16'h0,    16'h0,    16'h0,    16'h5A5A, 16, 8,  0};
        vecs[3] = '{1'b1, 16'h0200, 4'd2,  16'h0011, 16'h0022, 16'h0033, 16'h0033, 12, 6,  2};
        vecs[4] = '{1'b0, 16'h0000, 4'd15, 16'h0,    16'h0,    16'h0,    16'h1E1E, 64, 32, 0};

        for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
        mem[16'h0010] = 16'h003C;
        mem[16'h0001] = 16'h5A5A;
        mem[16'h000F] = 16'h1E1E;
        ma = model_reset();
        mb = model_reset();

        repeat (2) @(negedge clk);
        check("reset dut_a", obs_a, 54'd0);
        check("reset dut_b", obs_b, 54'd0);
        n_rst = 1'b1;

        for (int i = 0; i < 5; i++) apply_vec(vecs[i], i);

        // Asynchronous reset in the middle of word 2 of a burst.
        start = 1'b1; wmode = 1'b0; addr_in = 16'h0100; len_in = 4'd3;
        cycle();
        start = 1'b0;
        for (int t = 0; t < 20 && ma.k != 6; t++) cycle();
        check_int("reset point reached", ma.k, 6);
        @(posedge clk);
        #2 n_rst = 1'b0;
        #1;
        check("async reset dut_a", obs_a, 54'd0);
        check("async reset dut_b", obs_b, 54'd0);
        ma = model_reset();
        mb = model_reset();
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        repeat (6) cycle();
        apply_vec(vecs[0], 5);

        // Random traffic, with wrap-prone addresses favoured.
        for (int t = 0; t < 3000; t++) begin
            start   = ($urandom % 3) == 0;
            wmode   = 1'($urandom);
            addr_in = ($urandom % 4 == 0) ? 16'hFFFC + 16'($urandom % 4) : 16'($urandom);
            len_in  = 4'($urandom);
            wd_a    = 16'($urandom);
            wd_b    = 16'($urandom);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
